// File: rtl/traceback_sequencer.sv
// Traceback-phase sequencer for the NW engine: reads direction/sequence RAM,
// waits out its latency, steps the traceback datapath and streams aligned pairs.
module traceback_sequencer #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int SCORE_W = BitAddr + 1,
    parameter int RAM_LAT = 1,
    parameter int LEN_W   = $clog2(2 * N + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      end_c,
    input  logic [2:0]                datoA,
    input  logic [2:0]                datoB,
    input  logic signed [SCORE_W-1:0] final_score,
    output logic                      rd_en,
    output logic                      en_traceB,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_a,
    output logic [2:0]                out_b,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [LEN_W-1:0]          aln_len,
    output logic signed [SCORE_W-1:0] score_out
);

    // state  | meaning
    // IDLE   | waiting for start
    // RD     | RAM read strobe for current cell
    // WAIT   | counting down RAM latency
    // STEP   | one-cycle step enable to the traceback datapath
    // EMIT   | aligned pair presented, waiting for out_ready
    // DONE   | one-cycle completion pulse, score latched
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_STEP,
        S_EMIT,
        S_DONE
    } state_t;

    localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [LEN_W-1:0] LAST_PAIR = LEN_W'(2 * N - 1);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(2 * N);

    state_t           state, state_nx;
    logic [LAT_W-1:0] lat_cnt;
    logic             hs;

    assign hs = (state == S_EMIT) && out_ready && !abort;

    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        en_traceB = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: if (start) state_nx = S_RD;
            S_RD: begin
                rd_en    = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: if (lat_cnt == '0) state_nx = S_STEP;
            S_STEP: begin
                en_traceB = 1'b1;
                state_nx  = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (end_c || aln_len == LAST_PAIR) state_nx = S_DONE;
                    else                               state_nx = S_RD;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // abort wins over every transition, including start in IDLE
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            lat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_RD)
                lat_cnt <= LAT_W'(RAM_LAT - 1);
            else if (state == S_WAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_a     <= '0;
            out_b     <= '0;
            aln_len   <= '0;
            err       <= 1'b0;
            score_out <= '0;
        end else begin
            if (state == S_IDLE && state_nx == S_RD) begin
                aln_len <= '0;
                err     <= 1'b0;
            end
            if (state == S_STEP && state_nx == S_EMIT) begin
                out_a <= datoA;
                out_b <= datoB;
            end
            if (hs && aln_len != MAX_LEN)
                aln_len <= aln_len + 1'b1;
            // reaching the 2N-th pair without an origin means a corrupt path
            if (hs && !end_c && aln_len == LAST_PAIR)
                err <= 1'b1;
            if (state != S_DONE && state_nx == S_DONE)
                score_out <= final_score;
        end
    end

endmodule

// File: tb/tb_traceback_sequencer.sv
// Directed bench for traceback_sequencer: a cycle table for the basic path plus
// hand sequences for stalls, abort, step limit, start-while-busy and reset.
module tb_traceback_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b, abort, end_c, out_ready;
    logic [2:0] sym_a, sym_b;
    logic signed [8:0] fs_a;
    logic signed [3:0] fs_b;

    logic rd_a, en_a, ov_a, busy_a, done_a, err_a;
    logic [2:0] oa_a, ob_a;
    logic [8:0] len_a;
    logic signed [8:0] score_a;

    logic rd_b, en_b, ov_b, busy_b, done_b, err_b;
    logic [2:0] oa_b, ob_b;
    logic [3:0] len_b;
    logic signed [3:0] score_b;

    traceback_sequencer #(.N(128), .RAM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .end_c(end_c),
        .datoA(sym_a), .datoB(sym_b), .final_score(fs_a),
        .rd_en(rd_a), .en_traceB(en_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_a(oa_a), .out_b(ob_a), .busy(busy_a), .done(done_a), .err(err_a),
        .aln_len(len_a), .score_out(score_a)
    );

    traceback_sequencer #(.N(4), .RAM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .end_c(end_c),
        .datoA(sym_a), .datoB(sym_b), .final_score(fs_b),
        .rd_en(rd_b), .en_traceB(en_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_a(oa_b), .out_b(ob_b), .busy(busy_b), .done(done_b), .err(err_b),
        .aln_len(len_b), .score_out(score_b)
    );

    typedef struct {
        logic       start;
        logic       end_c;
        logic [2:0] da;
        logic [2:0] db;
        logic [4:0] exp_ctl;   // {rd_en, en_traceB, out_valid, done, busy}
        logic [2:0] exp_a;
        logic [2:0] exp_b;
        logic [8:0] exp_len;
    } vec_t;

    vec_t vecs[15];
    int checks = 0;
    int failures = 0;
    int k, gap, pairs, dones;

    function automatic vec_t mk(logic st, logic ec, logic [2:0] da, logic [2:0] db,
                                logic [4:0] ctl, logic [2:0] ea, logic [2:0] eb,
                                logic [8:0] el);
        vec_t v;
        v.start = st; v.end_c = ec; v.da = da; v.db = db;
        v.exp_ctl = ctl; v.exp_a = ea; v.exp_b = eb; v.exp_len = el;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 3-pair path, RAM_LAT=1, out_ready held high
        vecs[0]  = mk(1, 0, 0, 0, 5'b00000, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 5'b10001, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 5'b00001, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 4, 5'b01001, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 4, 5'b00101, 1, 4, 0);
        vecs[5]  = mk(0, 0, 1, 4, 5'b10001, 1, 4, 1);
        vecs[6]  = mk(0, 0, 1, 4, 5'b00001, 1, 4, 1);
        vecs[7]  = mk(0, 0, 2, 5, 5'b01001, 1, 4, 1);
        vecs[8]  = mk(0, 0, 2, 5, 5'b00101, 2, 5, 1);
        vecs[9]  = mk(0, 0, 2, 5, 5'b10001, 2, 5, 2);
        vecs[10] = mk(0, 0, 2, 5, 5'b00001, 2, 5, 2);
        vecs[11] = mk(0, 0, 7, 0, 5'b01001, 2, 5, 2);
        vecs[12] = mk(0, 1, 7, 0, 5'b00101, 7, 0, 2);
        vecs[13] = mk(0, 0, 7, 0, 5'b00011, 7, 0, 3);
        vecs[14] = mk(0, 0, 7, 0, 5'b00000, 7, 0, 3);

        rst = 1; start_a = 0; start_b = 0; abort = 0; end_c = 0; out_ready = 1;
        sym_a = 0; sym_b = 0; fs_a = -9'sd5; fs_b = 4'sd3;
        tick; tick;
        check("reset_a", {2'b0, rd_a, en_a, ov_a, oa_a, ob_a, busy_a, done_a, err_a, len_a, score_a}, 32'd0);
        check("reset_b", {12'b0, rd_b, en_b, ov_b, oa_b, ob_b, busy_b, done_b, err_b, len_b, score_b}, 32'd0);
        rst = 0;
        tick;

        for (int i = 0; i < 15; i++) begin
            start_a = vecs[i].start; end_c = vecs[i].end_c;
            sym_a = vecs[i].da; sym_b = vecs[i].db;
            check($sformatf("t1_row%0d", i),
                  {9'b0, rd_a, en_a, ov_a, done_a, busy_a, oa_a, ob_a, len_a},
                  {9'b0, vecs[i].exp_ctl, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_len});
            tick;
        end
        start_a = 0; end_c = 0;
        check("t1_score", {23'd0, score_a}, 32'h1FB);
        check("t1_err", {31'd0, err_a}, 32'd0);

        // stall 5 cycles in EMIT
        out_ready = 0; sym_a = 3; sym_b = 6;
        start_a = 1; tick; start_a = 0;
        k = 0;
        while (!ov_a && k < 20) begin tick; k++; end
        check("t3_reach_emit", {31'd0, ov_a}, 32'd1);
        sym_a = 0; sym_b = 0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("t3_stall%0d", c), {ov_a, rd_a, en_a, oa_a, ob_a, len_a},
                  {1'b1, 1'b0, 1'b0, 3'd3, 3'd6, 9'd0});
            tick;
        end
        out_ready = 1; end_c = 1;
        tick;
        end_c = 0;
        check("t3_handshake", {done_a, len_a}, {1'b1, 9'd1});
        tick;

        // abort during WAIT of the second step
        sym_a = 5; sym_b = 2;
        start_a = 1; tick; start_a = 0;
        k = 0;
        while (!ov_a && k < 20) begin tick; k++; end
        check("t4_reach_emit", {31'd0, ov_a}, 32'd1);
        tick;
        check("t4_rd2", {rd_a, len_a}, {1'b1, 9'd1});
        tick;
        abort = 1;
        check("t4_in_wait", {rd_a, en_a, ov_a, busy_a}, 4'b0001);
        tick;
        abort = 0;
        check("t4_abort", {busy_a, rd_a, en_a, ov_a, done_a, len_a}, {5'b0, 9'd1});
        dones = 0;
        repeat (4) begin dones += int'(done_a); tick; end
        check("t4_no_done", dones, 0);
        check("t4_idle", {31'd0, busy_a}, 32'd0);

        // start together with abort in IDLE
        start_a = 1; abort = 1; tick; start_a = 0; abort = 0;
        check("idle_start_abort", {busy_a, rd_a}, 2'b00);

        // start while busy, then reset mid-EMIT
        sym_a = 4; sym_b = 1;
        start_a = 1; tick; start_a = 0;
        k = 0;
        while (!ov_a && k < 20) begin tick; k++; end
        check("t6_reach_emit", {31'd0, ov_a}, 32'd1);
        tick;
        start_a = 1; tick; start_a = 0;
        check("t6_start_ignored", {busy_a, len_a}, {1'b1, 9'd1});
        tick;
        check("t6_step", {31'd0, en_a}, 32'd1);
        out_ready = 0;
        tick;
        check("t6_emit", {ov_a, oa_a, ob_a}, {1'b1, 3'd4, 3'd1});
        rst = 1; tick; rst = 0;
        check("t6_rst", {2'b0, rd_a, en_a, ov_a, oa_a, ob_a, busy_a, done_a, err_a, len_a, score_a}, 32'd0);
        tick;
        check("t6_stays_idle", {busy_a, rd_a}, 2'b00);
        out_ready = 1;

        // RAM_LAT=3: rd_en to en_traceB spacing on every step
        start_b = 1; tick; start_b = 0;
        for (int s = 0; s < 3; s++) begin
            k = 0;
            while (!rd_b && k < 30) begin tick; k++; end
            check($sformatf("t2_rd%0d", s), {31'd0, rd_b}, 32'd1);
            gap = 0;
            while (!en_b && gap < 20) begin tick; gap++; end
            check($sformatf("t2_gap%0d", s), gap, 4);
            end_c = (s == 2);
            k = 0;
            while (!ov_b && k < 20) begin tick; k++; end
            tick;
            end_c = 0;
        end
        check("t2_done", {done_b, len_b}, {1'b1, 4'd3});
        tick;
        check("t2_final", {busy_b, err_b, len_b, score_b}, {1'b0, 1'b0, 4'd3, 4'd3});

        // N=4 step limit: 8 pairs without end_c
        start_b = 1; tick; start_b = 0;
        pairs = 0; dones = 0; k = 0;
        while (k < 300 && !(dones > 0 && !busy_b)) begin
            if (ov_b) pairs++;
            if (done_b) dones++;
            tick; k++;
        end
        check("t5_pairs", pairs, 8);
        check("t5_dones", dones, 1);
        check("t5_err_len", {err_b, len_b}, {1'b1, 4'd8});
        start_b = 1; tick; start_b = 0;
        check("t5_err_clear", {err_b, busy_b, len_b}, {1'b0, 1'b1, 4'd0});
        abort = 1; tick; abort = 0; tick;
        check("t5_abort_idle", {busy_b, done_b}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
